// File: rtl/nexys_starship_repair_bank.sv
// Multi-part damage/repair controller: parts arm after a safe delay, break at random,
// and must be repaired with their captured combo before the repair deadline expires.
module nexys_starship_repair_bank #(
    parameter int unsigned NUM_PARTS    = 4,
    parameter int unsigned COMBO_W      = 4,
    parameter int unsigned SAFE_TICKS   = 2,
    parameter int unsigned REPAIR_LIMIT = 30,
    parameter int unsigned PENALTY      = 5
) (
    input  logic                         timer_clk,
    input  logic                         Reset,
    input  logic                         play_flag,
    input  logic                         gameover_ctrl,
    input  logic [NUM_PARTS-1:0]         break_req,
    input  logic [NUM_PARTS-1:0]         shield,
    input  logic [COMBO_W-1:0]           random_hex,
    input  logic [COMBO_W-1:0]           hex_combo,
    input  logic [NUM_PARTS-1:0]         submit,
    output logic [NUM_PARTS-1:0]         broken,
    output logic [NUM_PARTS*COMBO_W-1:0] combo_flat,
    output logic [3:0]                   broken_count,
    output logic                         ship_fail,
    output logic [2:0]                   fail_part,
    output logic [1:0]                   game_state
);

    localparam int unsigned MAX_CNT = (SAFE_TICKS > REPAIR_LIMIT + PENALTY) ?
                                      SAFE_TICKS : REPAIR_LIMIT + PENALTY;
    localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   sum_t;

    localparam cnt_t SAFE_LAST = cnt_t'(SAFE_TICKS - 1);
    localparam sum_t LIMIT     = sum_t'(REPAIR_LIMIT);
    localparam sum_t PEN       = sum_t'(PENALTY);

    typedef enum logic [1:0] {GsIdle = 2'b00, GsRun = 2'b01, GsFailed = 2'b10} game_state_e;
    typedef enum logic [1:0] {PtSafe, PtArmed, PtBroken} part_state_e;

    game_state_e                  game_state_q, game_state_d;
    part_state_e                  part_state_q [NUM_PARTS];
    part_state_e                  part_state_d [NUM_PARTS];
    cnt_t                         safe_cnt_q   [NUM_PARTS];
    cnt_t                         safe_cnt_d   [NUM_PARTS];
    cnt_t                         age_q        [NUM_PARTS];
    cnt_t                         age_d        [NUM_PARTS];
    logic [NUM_PARTS*COMBO_W-1:0] combo_q, combo_d;
    logic [NUM_PARTS-1:0]         broken_q, broken_d;
    logic [3:0]                   count_q, count_d;
    logic                         ship_fail_q, ship_fail_d;
    logic [2:0]                   fail_part_q, fail_part_d;
    logic [NUM_PARTS-1:0]         miss;
    logic                         taken;
    sum_t                         age_sum;

    always_comb begin
        game_state_d = game_state_q;
        combo_d      = combo_q;
        ship_fail_d  = ship_fail_q;
        fail_part_d  = fail_part_q;
        miss         = '0;
        taken        = 1'b0;
        age_sum      = '0;
        for (int i = 0; i < NUM_PARTS; i++) begin
            part_state_d[i] = part_state_q[i];
            safe_cnt_d[i]   = safe_cnt_q[i];
            age_d[i]        = age_q[i];
        end

        if (game_state_q == GsRun) begin
            for (int i = 0; i < NUM_PARTS; i++) begin
                unique case (part_state_q[i])
                    PtSafe: begin
                        if (safe_cnt_q[i] == SAFE_LAST) begin
                            part_state_d[i] = PtArmed;
                            safe_cnt_d[i]   = '0;
                        end else begin
                            safe_cnt_d[i] = safe_cnt_q[i] + cnt_t'(1);
                        end
                    end
                    PtArmed: begin
                        // Lowest-index eligible part wins; at most one break per tick.
                        if (break_req[i] && !shield[i] && !taken) begin
                            taken                         = 1'b1;
                            part_state_d[i]               = PtBroken;
                            combo_d[i*COMBO_W +: COMBO_W] = random_hex;
                            age_d[i]                      = '0;
                        end
                    end
                    PtBroken: begin
                        if (submit[i] && hex_combo == combo_q[i*COMBO_W +: COMBO_W]) begin
                            part_state_d[i]               = PtSafe;
                            combo_d[i*COMBO_W +: COMBO_W] = '0;
                            safe_cnt_d[i]                 = '0;
                            age_d[i]                      = '0;
                        end else begin
                            age_sum = {1'b0, age_q[i]} + (submit[i] ? PEN : sum_t'(1));
                            if (age_sum >= LIMIT) begin
                                age_sum = LIMIT;
                                miss[i] = 1'b1;
                            end
                            age_d[i] = age_sum[CNT_W-1:0];
                        end
                    end
                    default: part_state_d[i] = PtSafe;
                endcase
            end
        end

        case (game_state_q)
            GsIdle: if (play_flag) game_state_d = GsRun;
            GsRun: begin
                if (|miss) begin
                    game_state_d = GsFailed;
                    ship_fail_d  = 1'b1;
                    for (int i = int'(NUM_PARTS) - 1; i >= 0; i--) begin
                        if (miss[i]) fail_part_d = 3'(i);
                    end
                end
            end
            default: ;
        endcase

        // Abort overrides every other event in the same tick.
        if (gameover_ctrl && game_state_q != GsIdle) begin
            game_state_d = GsIdle;
            combo_d      = '0;
            ship_fail_d  = 1'b0;
            fail_part_d  = '0;
            for (int i = 0; i < NUM_PARTS; i++) begin
                part_state_d[i] = PtSafe;
                safe_cnt_d[i]   = '0;
                age_d[i]        = '0;
            end
        end

        count_d = '0;
        for (int i = 0; i < NUM_PARTS; i++) begin
            broken_d[i] = (part_state_d[i] == PtBroken);
            count_d     = count_d + 4'(broken_d[i]);
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            game_state_q <= GsIdle;
            combo_q      <= '0;
            broken_q     <= '0;
            count_q      <= '0;
            ship_fail_q  <= 1'b0;
            fail_part_q  <= '0;
            for (int i = 0; i < NUM_PARTS; i++) begin
                part_state_q[i] <= PtSafe;
                safe_cnt_q[i]   <= '0;
                age_q[i]        <= '0;
            end
        end else begin
            game_state_q <= game_state_d;
            combo_q      <= combo_d;
            broken_q     <= broken_d;
            count_q      <= count_d;
            ship_fail_q  <= ship_fail_d;
            fail_part_q  <= fail_part_d;
            for (int i = 0; i < NUM_PARTS; i++) begin
                part_state_q[i] <= part_state_d[i];
                safe_cnt_q[i]   <= safe_cnt_d[i];
                age_q[i]        <= age_d[i];
            end
        end
    end

    assign broken       = broken_q;
    assign combo_flat   = combo_q;
    assign broken_count = count_q;
    assign ship_fail    = ship_fail_q;
    assign fail_part    = fail_part_q;
    assign game_state   = game_state_q;

endmodule

// File: tb/tb_nexys_starship_repair_bank.sv
// Directed bench for nexys_starship_repair_bank: arming, arbitration, repair, penalty,
// deadline miss, shielding and abort, all with hand-computed expectations.
module tb_nexys_starship_repair_bank;

    logic        timer_clk = 1'b0;
    logic        Reset;
    logic        play_flag, gameover_ctrl;
    logic [3:0]  break_req, shield, submit;
    logic [3:0]  random_hex, hex_combo;
    logic [3:0]  broken;
    logic [15:0] combo_flat;
    logic [3:0]  broken_count;
    logic        ship_fail;
    logic [2:0]  fail_part;
    logic [1:0]  game_state;

    int checks = 0;
    int errors = 0;

    nexys_starship_repair_bank dut (
        .timer_clk    (timer_clk),
        .Reset        (Reset),
        .play_flag    (play_flag),
        .gameover_ctrl(gameover_ctrl),
        .break_req    (break_req),
        .shield       (shield),
        .random_hex   (random_hex),
        .hex_combo    (hex_combo),
        .submit       (submit),
        .broken       (broken),
        .combo_flat   (combo_flat),
        .broken_count (broken_count),
        .ship_fail    (ship_fail),
        .fail_part    (fail_part),
        .game_state   (game_state)
    );

    always #5 timer_clk = ~timer_clk;

    task automatic tick();
        @(posedge timer_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_parts(input string tag, input logic [3:0] b, input logic [15:0] c,
                             input logic [3:0] n);
        chk({tag, " broken"}, 32'(broken), 32'(b));
        chk({tag, " combo"}, 32'(combo_flat), 32'(c));
        chk({tag, " count"}, 32'(broken_count), 32'(n));
    endtask

    task automatic chk_game(input string tag, input logic [1:0] gs, input logic sf,
                            input logic [2:0] fp);
        chk({tag, " state"}, 32'(game_state), 32'(gs));
        chk({tag, " ship_fail"}, 32'(ship_fail), 32'(sf));
        chk({tag, " fail_part"}, 32'(fail_part), 32'(fp));
    endtask

    initial begin
        Reset = 1'b1; play_flag = 0; gameover_ctrl = 0;
        break_req = 0; shield = 0; submit = 0; random_hex = 0; hex_combo = 0;
        #1;
        chk_parts("reset", 4'b0000, 16'h0000, 4'd0);
        chk_game("reset", 2'b00, 1'b0, 3'd0);
        tick(); tick();
        Reset = 1'b0;

        // Start, arm after two RUN ticks, arbitration between parts 1 and 2
        play_flag = 1; tick(); play_flag = 0;
        chk_game("start", 2'b01, 1'b0, 3'd0);
        break_req = 4'b0110; random_hex = 4'hA;
        tick(); chk_parts("safe1", 4'b0000, 16'h0000, 4'd0);
        tick(); chk_parts("safe2", 4'b0000, 16'h0000, 4'd0);
        tick(); chk_parts("win1", 4'b0010, 16'h00A0, 4'd1);
        random_hex = 4'h5;
        tick(); chk_parts("win2", 4'b0110, 16'h05A0, 4'd2);
        break_req = 4'b0001; random_hex = 4'h3;
        tick(); chk_parts("brk0", 4'b0111, 16'h05A3, 4'd3);

        // Correct repair of part 0, then re-arm takes two ticks
        break_req = 0; submit = 4'b0001; hex_combo = 4'h3;
        tick(); submit = 0;
        chk_parts("rep0", 4'b0110, 16'h05A0, 4'd2);
        break_req = 4'b0001; random_hex = 4'hC;
        tick(); chk_parts("rearm1", 4'b0110, 16'h05A0, 4'd2);
        tick(); chk_parts("rearm2", 4'b0110, 16'h05A0, 4'd2);
        tick(); chk_parts("rebrk0", 4'b0111, 16'h05AC, 4'd3);
        break_req = 0;

        submit = 4'b0100; hex_combo = 4'h5;
        tick(); chk_parts("rep2", 4'b0011, 16'h00AC, 4'd2);
        submit = 4'b0010; hex_combo = 4'h0;
        tick(); chk_parts("wrong1", 4'b0011, 16'h00AC, 4'd2);
        submit = 4'b0010; hex_combo = 4'hA;
        tick(); submit = 0;
        chk_parts("rep1", 4'b0001, 16'h000C, 4'd1);

        // Part 0 is at age 3; advance to age 24, wrong submit -> 29, then miss
        repeat (21) tick();
        chk_game("age24", 2'b01, 1'b0, 3'd0);
        submit = 4'b0001; hex_combo = 4'h0;
        tick(); submit = 0;
        chk_game("age29", 2'b01, 1'b0, 3'd0);
        tick();
        chk_game("miss0", 2'b10, 1'b1, 3'd0);
        chk_parts("miss0", 4'b0001, 16'h000C, 4'd1);

        // FAILED freezes parts, even against a correct submit
        break_req = 4'b1111; submit = 4'b0001; hex_combo = 4'hC;
        tick(); tick(); tick();
        break_req = 0; submit = 0;
        chk_parts("frozen", 4'b0001, 16'h000C, 4'd1);
        chk_game("frozen", 2'b10, 1'b1, 3'd0);

        gameover_ctrl = 1; tick(); gameover_ctrl = 0;
        chk_parts("abortF", 4'b0000, 16'h0000, 4'd0);
        chk_game("abortF", 2'b00, 1'b0, 3'd0);

        // Shield holds off an armed part for 10 ticks
        play_flag = 1; tick(); play_flag = 0;
        shield = 4'b0100; break_req = 4'b0100;
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("shielded", 32'(broken), 32'h0);
        end
        shield = 0; random_hex = 4'h7;
        tick(); chk_parts("unshield", 4'b0100, 16'h0700, 4'd1);
        shield = 4'b0001; break_req = 4'b0011; random_hex = 4'h9;
        tick(); chk_parts("shield0", 4'b0110, 16'h0790, 4'd2);
        shield = 0; break_req = 4'b0001; random_hex = 4'h2;
        tick(); chk_parts("three", 4'b0111, 16'h0792, 4'd3);
        break_req = 0;

        // Abort in RUN with three broken; abort beats play_flag
        gameover_ctrl = 1; play_flag = 1;
        tick(); gameover_ctrl = 0; play_flag = 0;
        chk_parts("abortR", 4'b0000, 16'h0000, 4'd0);
        chk_game("abortR", 2'b00, 1'b0, 3'd0);
        tick(); chk_game("idle", 2'b00, 1'b0, 3'd0);

        // Correct submit on the limit tick wins; part 2 then misses
        play_flag = 1; tick(); play_flag = 0;
        break_req = 4'b0101; random_hex = 4'h7;
        tick(); tick();
        tick(); chk_parts("g_win0", 4'b0001, 16'h0007, 4'd1);
        random_hex = 4'h9;
        tick(); chk_parts("g_brk2", 4'b0101, 16'h0907, 4'd2);
        break_req = 0;
        repeat (28) tick();
        chk_game("g_age29", 2'b01, 1'b0, 3'd0);
        submit = 4'b0001; hex_combo = 4'h7;
        tick(); submit = 0;
        chk_parts("g_limrep", 4'b0100, 16'h0900, 4'd1);
        chk_game("g_limrep", 2'b01, 1'b0, 3'd0);
        tick();
        chk_game("g_miss2", 2'b10, 1'b1, 3'd2);
        chk_parts("g_miss2", 4'b0100, 16'h0900, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
